// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR oversampling averager/decimator.
package sar_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam int OSR_LOG2_MAX_DEF = 3;
  localparam int OSR_SEL_W        = 2;

endpackage : sar_pkg

// File: rtl/sar_avg_decim_if.sv
// Sample-in / result-out bundle for sar_avg_decim; master is the SAR/consumer side.
interface sar_avg_decim_if #(
  parameter int DW = 8
);
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;

  modport master (
    output smp_valid, smp_data, res_ready,
    input  res_valid, res_data
  );

  modport slave (
    input  smp_valid, smp_data, res_ready,
    output res_valid, res_data
  );
endinterface : sar_avg_decim_if

// File: rtl/sar_res_reg.sv
// Valid/ready result holding register with sticky drop flag for sar_avg_decim.
module sar_res_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          idle_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          res_ready_i,
  output logic          res_valid_o,
  output logic [DW-1:0] res_data_o,
  output logic          ovf_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic          ovf_q,   ovf_d;
  logic          accept;

  assign accept = valid_q && res_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (load_i) begin
      // A completing result may replace the old one only when the slot frees this cycle.
      if (!valid_q || res_ready_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (idle_i) ovf_d = 1'b0;
  end

  // NOTE: the data register is reset too so res_data reads 0 after reset, not stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign res_valid_o = valid_q;
  assign res_data_o  = data_q;
  assign ovf_o       = ovf_q;

endmodule : sar_res_reg

// File: rtl/sar_avg_decim.sv
// Averages 2^osr_sel consecutive SAR codes and emits one truncated mean per window.
module sar_avg_decim
  import sar_pkg::*;
#(
  parameter int DW           = 8,
  parameter int OSR_LOG2_MAX = OSR_LOG2_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [OSR_SEL_W-1:0] osr_sel,
  input  logic                 smp_valid,
  input  logic [DW-1:0]        smp_data,
  output logic                 res_valid,
  output logic [DW-1:0]        res_data,
  input  logic                 res_ready,
  output logic                 ovf
);

  localparam int AW = DW + OSR_LOG2_MAX;
  localparam int CW = OSR_LOG2_MAX;

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q,   acc_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [OSR_SEL_W-1:0] osr_q,   osr_d;

  logic [AW-1:0]        sum;
  logic [CW-1:0]        last_cnt;
  logic [OSR_SEL_W-1:0] osr_clamp;
  logic [DW-1:0]        result;
  logic                 done;

  assign sum       = acc_q + AW'(smp_data);
  assign last_cnt  = CW'((1 << osr_q) - 1);
  assign osr_clamp = (int'(osr_sel) > OSR_LOG2_MAX) ? OSR_SEL_W'(OSR_LOG2_MAX) : osr_sel;
  assign result    = DW'(sum >> osr_q);

  // NOTE: every next-state signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    osr_d   = osr_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) begin
          state_d = ST_ACC;
          osr_d   = osr_clamp;
        end
      end
      ST_ACC: begin
        if (!en) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (smp_valid) begin
          if (cnt_q == last_cnt) begin
            // Window closes: clear and pick up the ratio for the next window.
            done  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            osr_d = osr_clamp;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      osr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      osr_q   <= osr_d;
    end
  end

  sar_res_reg #(.DW(DW)) u_res_reg (
    .clk         (clk),
    .rst         (rst),
    .idle_i      (state_q == ST_IDLE),
    .load_i      (done),
    .data_i      (result),
    .res_ready_i (res_ready),
    .res_valid_o (res_valid),
    .res_data_o  (res_data),
    .ovf_o       (ovf)
  );

endmodule : sar_avg_decim

// File: tb/tb_sar_avg_decim.sv
// Directed self-checking bench for sar_avg_decim with hand-computed expectations.
module tb_sar_avg_decim;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] osr_sel;
  logic       ovf;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  sar_avg_decim_if #(.DW(8)) bus ();

  sar_avg_decim #(.DW(8), .OSR_LOG2_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .osr_sel   (osr_sel),
    .smp_valid (bus.smp_valid),
    .smp_data  (bus.smp_data),
    .res_valid (bus.res_valid),
    .res_data  (bus.res_data),
    .res_ready (bus.res_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [7:0] d);
    bus.smp_valid = 1'b1;
    bus.smp_data  = d;
    tick();
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
  endtask

  // Drop to IDLE for two cycles (clears ovf) and re-enter ACC with a new ratio.
  task automatic restart(input logic [1:0] osr);
    en = 1'b0;
    tick();
    tick();
    osr_sel = osr;
    en = 1'b1;
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b0;
    osr_sel       = 2'd0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data",  32'(bus.res_data),  32'h00);
    check("rst_ovf",   32'(ovf),           32'd0);

    // Pass-through, second result loads on the same cycle as the first handshake
    en = 1'b1;
    tick();
    sample(8'h12);
    check("pt1_valid", 32'(bus.res_valid), 32'd1);
    check("pt1_data",  32'(bus.res_data),  32'h12);
    check("pt1_ovf",   32'(ovf),           32'd0);
    sample(8'hFF);
    check("pt2_valid", 32'(bus.res_valid), 32'd1);
    check("pt2_data",  32'(bus.res_data),  32'hFF);
    check("pt2_ovf",   32'(ovf),           32'd0);
    tick();
    check("pt_drain",  32'(bus.res_valid), 32'd0);

    // Full-scale OSR=8: 8*0xFF = 0x7F8, >>3 = 0xFF
    restart(2'd3);
    for (int i = 0; i < 7; i++) begin
      sample(8'hFF);
      check("fs_no_early", 32'(bus.res_valid), 32'd0);
    end
    sample(8'hFF);
    check("fs_valid", 32'(bus.res_valid), 32'd1);
    check("fs_data",  32'(bus.res_data),  32'hFF);
    tick();
    check("fs_drain", 32'(bus.res_valid), 32'd0);

    // Truncation with mid-window osr_sel change: (1+2+3+4)>>2 = 2
    restart(2'd2);
    sample(8'd1);
    sample(8'd2);
    osr_sel = 2'd0;
    sample(8'd3);
    check("tr_mid", 32'(bus.res_valid), 32'd0);
    sample(8'd4);
    check("tr_valid", 32'(bus.res_valid), 32'd1);
    check("tr_data",  32'(bus.res_data),  32'h02);
    tick();
    check("tr_drain", 32'(bus.res_valid), 32'd0);
    sample(8'h33);
    check("tr_osr1_valid", 32'(bus.res_valid), 32'd1);
    check("tr_osr1_data",  32'(bus.res_data),  32'h33);
    tick();

    // Backpressure: second result dropped, ovf set, old data kept
    bus.res_ready = 1'b0;
    sample(8'h10);
    check("bp1_valid", 32'(bus.res_valid), 32'd1);
    check("bp1_data",  32'(bus.res_data),  32'h10);
    check("bp1_ovf",   32'(ovf),           32'd0);
    sample(8'h20);
    check("bp2_valid", 32'(bus.res_valid), 32'd1);
    check("bp2_data",  32'(bus.res_data),  32'h10);
    check("bp2_ovf",   32'(ovf),           32'd1);
    bus.res_ready = 1'b1;
    tick();
    check("bp_drain", 32'(bus.res_valid), 32'd0);
    check("bp_ovf_sticky", 32'(ovf),      32'd1);

    // Abort after 3 of 4 samples, then a clean window of 0x40
    osr_sel = 2'd2;
    restart(2'd2);
    check("ab_ovf_clr", 32'(ovf), 32'd0);
    sample(8'h50);
    sample(8'h50);
    sample(8'h50);
    en = 1'b0;
    tick();
    check("ab_no_valid", 32'(bus.res_valid), 32'd0);
    tick();
    tick();
    check("ab_idle_valid", 32'(bus.res_valid), 32'd0);
    check("ab_idle_ovf",   32'(ovf),           32'd0);
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) sample(8'h40);
    check("ab_valid", 32'(bus.res_valid), 32'd1);
    check("ab_data",  32'(bus.res_data),  32'h40);
    tick();

    // Reset mid-window with a pending result, then (8+9+10+11)>>2 = 9
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(8'h30);
    check("rs_pending", 32'(bus.res_data), 32'h30);
    sample(8'h11);
    sample(8'h11);
    rst = 1'b1;
    bus.smp_valid = 1'b1;
    bus.smp_data  = 8'h77;
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.smp_valid = 1'b0;
    check("rs_valid", 32'(bus.res_valid), 32'd0);
    check("rs_data",  32'(bus.res_data),  32'h00);
    check("rs_ovf",   32'(ovf),           32'd0);
    tick();
    sample(8'h08);
    sample(8'h09);
    sample(8'h0A);
    check("rs_mid", 32'(bus.res_valid), 32'd0);
    sample(8'h0B);
    check("rs_win_valid", 32'(bus.res_valid), 32'd1);
    check("rs_win_data",  32'(bus.res_data),  32'h09);
    tick();
    check("rs_drain", 32'(bus.res_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_sar_avg_decim

// File: doc/sar_avg_decim.md
SAR_AVG_DECIM -- requirements
Module: sar_avg_decim

Interface
REQ-001 SHALL provide parameter DW, default 8, the SAR code width in bits.
REQ-002 SHALL provide parameter OSR_LOG2_MAX, default 3, the maximum oversampling exponent (OSR up to 8).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1, decimator enable.
REQ-006 SHALL have port osr_sel, input, 2, oversampling ratio select: N = 2^osr_sel, so 1, 2, 4 or 8.
REQ-007 SHALL have port smp_valid, input, 1, a one-cycle strobe that a SAR conversion is complete.
REQ-008 SHALL have port smp_data, input, DW, the SAR output code, unsigned.
REQ-009 SHALL have port res_valid, output, 1, averaged result available.
REQ-010 SHALL have port res_data, output, DW, the averaged result.
REQ-011 SHALL have port res_ready, input, 1, consumer acceptance of the result.
REQ-012 SHALL have port ovf, output, 1, sticky flag that a result was dropped.

Function
REQ-013 SHALL implement FSM states IDLE and ACC.
- IDLE -> ACC on the cycle after en=1.
- ACC -> IDLE on the cycle after en=0.
REQ-014 SHALL, in IDLE, hold accumulator and sample counter at 0 and ignore smp_valid.
REQ-015 SHALL latch osr_sel into osr_q at each window start: entry to ACC, or the cycle after a window completes. osr_sel changes mid-window have no effect until the next window.
REQ-016 SHALL, in ACC, add smp_data to an accumulator of width DW+OSR_LOG2_MAX and increment the sample counter on each smp_valid. The accumulator shall never overflow.
REQ-017 SHALL complete a window when smp_valid arrives with count = 2^osr_q - 1:
- result = (acc + smp_data) >> osr_q, truncated, no rounding;
- accumulator and counter clear in the same cycle.
REQ-018 SHALL present the result with 1-cycle latency: res_valid=1 on the cycle after the final sample is accepted.
REQ-019 SHALL hold res_valid and res_data stable until a cycle with res_valid and res_ready both 1; res_valid falls the next cycle unless a new result loads.
REQ-020 SHALL, when a new result completes on the same cycle as a handshake, load the new result and keep res_valid=1; ovf is not set.
REQ-021 SHALL, when a new result completes while res_valid=1 and res_ready=0, discard the new result, keep the old one, and set ovf=1.
REQ-022 SHALL, on en falling mid-window, discard the partial sum; a result already pending in the output register remains until handshake.
REQ-023 SHALL clear ovf only on rst or while in IDLE.
REQ-024 SHALL, with osr_q=0, pass each sample through unchanged with 1-cycle latency.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, force state=IDLE, acc=0, count=0, osr_q=0, res_valid=0, res_data=0 and ovf=0, regardless of an in-progress window or a pending result.
REQ-026 SHALL give rst priority over en, smp_valid and res_ready in the same cycle.

Structure
REQ-027 SHALL place the FSM state enum and the OSR_LOG2_MAX default in shared package sar_pkg.
REQ-028 SHALL implement the valid/ready output register and the ovf logic as sub-module sar_res_reg; accumulation and the FSM stay in sar_avg_decim.

Verification
REQ-029 SHALL cover pass-through: DW=8, osr_sel=0, res_ready=1, samples 0x12 then 0xFF -> res_data 0x12 then 0xFF, each 1 cycle after its strobe, ovf=0.
REQ-030 SHALL cover full-scale: osr_sel=3, eight samples of 0xFF -> single res_data=0xFF (0x7F8>>3), no intermediate res_valid.
REQ-031 SHALL cover truncation and latching: osr_sel=2, samples 1,2,3,4, with osr_sel changed to 0 after the second sample -> res_data=0x02; the next window runs at OSR=1.
REQ-032 SHALL cover backpressure: osr_sel=0, res_ready=0, samples 0x10 then 0x20 -> res_data stays 0x10 and ovf=1; then res_ready=1 -> 0x10 accepted, res_valid=0 next cycle.
REQ-033 SHALL cover abort: osr_sel=2, en=0 after 3 samples -> no res_valid and ovf cleared; re-enable and send 4 samples of 0x40 -> res_data=0x40.
REQ-034 SHALL cover reset mid-operation: rst=1 mid-window with res_valid=1 -> the next cycle shows res_valid=0, res_data=0, ovf=0, and the first post-reset window yields the correct average.
